pid_sequencer: RTL and testbench

Time-multiplexed PID control core that sits directly around the shared 16-bit multiplier. It drives the multiplier's operands, computes error, integral and derivative terms, and accumulates the three gain products over successive cycles. It produces one saturated 16-bit actuator command per accepted sample. The multiplier is instantiated outside this block; its low-16-bit product is returned combinationally on `mul_p`.

---
 rtl/pid_pkg.sv | 19 +
 rtl/pid_sat.sv | 25 ++
 rtl/pid_sequencer.sv | 153 +++++++++++++++
 tb/tb_pid_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and constants for the time-multiplexed PID core.
package pid_pkg;

    localparam int PID_W     = 16;
    localparam int PID_ACC_W = 18;

    localparam logic signed [PID_W-1:0] SAT_MAX = 16'sh7fff;
    localparam logic signed [PID_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MP,
        S_MI,
        S_MD,
        S_OUT
    } state_t;

endpackage

// File: rtl/pid_sat.sv
// Signed saturator: clamps an N-bit signed value into the 16-bit range.
module pid_sat
    import pid_pkg::*;
#(
    parameter int N = 17
) (
    input  logic [N-1:0]     din,
    output logic [PID_W-1:0] dout
);

    localparam logic signed [N-1:0] HI = N'(SAT_MAX);
    // ~HI is the N-bit sign extension of SAT_MIN for any N >= 16
    localparam logic signed [N-1:0] LO = ~HI;

    always_comb begin
        if ($signed(din) > HI) begin
            dout = SAT_MAX;
        end else if ($signed(din) < LO) begin
            dout = SAT_MIN;
        end else begin
            dout = din[PID_W-1:0];
        end
    end

endmodule

// File: rtl/pid_sequencer.sv
// PID core sequencing one shared external multiplier over MP/MI/MD cycles.
// Optional integral clamp to +/-INT_LIMIT when PID_ANTIWINDUP_EN is defined.
module pid_sequencer
    import pid_pkg::*;
#(
    parameter logic signed [15:0] INT_LIMIT = 16'sd8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [15:0] setpoint,
    input  logic [15:0] feedback,
    input  logic [15:0] kp,
    input  logic [15:0] ki,
    input  logic [15:0] kd,
    input  logic        clr,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [15:0] mul_p,
    output logic [15:0] u,
    output logic        u_valid,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    state_t state;

    logic [15:0] sp_q;
    logic [15:0] fb_q;
    logic [15:0] e;
    logic [15:0] i;
    logic [15:0] d;
    logic [15:0] e_prev;
    logic [17:0] acc;

    logic [16:0] e_raw;
    logic [16:0] i_raw;
    logic [16:0] d_raw;
    logic [15:0] e_n;
    logic [15:0] i_s;
    logic [15:0] i_n;
    logic [15:0] d_n;
    logic [15:0] u_n;
    logic [17:0] prod;

    assign e_raw = {sp_q[15], sp_q} - {fb_q[15], fb_q};
    assign i_raw = {i[15], i} + {e_n[15], e_n};
    assign d_raw = {e_n[15], e_n} - {e_prev[15], e_prev};
    assign prod  = {{2{mul_p[15]}}, mul_p};

    pid_sat #(.N(17)) u_sat_e (.din(e_raw), .dout(e_n));
    pid_sat #(.N(17)) u_sat_i (.din(i_raw), .dout(i_s));
    pid_sat #(.N(17)) u_sat_d (.din(d_raw), .dout(d_n));
    pid_sat #(.N(PID_ACC_W)) u_sat_u (.din(acc), .dout(u_n));

`ifdef PID_ANTIWINDUP_EN
    always_comb begin
        i_n = i_s;
        if ($signed(i_s) > INT_LIMIT) begin
            i_n = INT_LIMIT;
        end else if ($signed(i_s) < -INT_LIMIT) begin
            i_n = -INT_LIMIT;
        end
    end
`else
    assign i_n = i_s;
`endif

    // Operands are zero outside the three multiply cycles
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            S_MP: begin
                mul_a = kp;
                mul_b = e;
            end
            S_MI: begin
                mul_a = ki;
                mul_b = i;
            end
            S_MD: begin
                mul_a = kd;
                mul_b = d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sp_q     <= '0;
            fb_q     <= '0;
            e        <= '0;
            i        <= '0;
            d        <= '0;
            e_prev   <= '0;
            acc      <= '0;
            u        <= '0;
            u_valid  <= 1'b0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            u_valid <= 1'b0;
            if (sample_valid && state != S_IDLE && drop_cnt != 8'hff) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            unique case (state)
                S_IDLE: begin
                    if (clr) begin
                        i      <= '0;
                        e_prev <= '0;
                    end
                    if (sample_valid) begin
                        sp_q  <= setpoint;
                        fb_q  <= feedback;
                        busy  <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_ERR: begin
                    e      <= e_n;
                    i      <= i_n;
                    d      <= d_n;
                    e_prev <= e_n;
                    state  <= S_MP;
                end
                S_MP: begin
                    acc   <= prod;
                    state <= S_MI;
                end
                S_MI: begin
                    acc   <= acc + prod;
                    state <= S_MD;
                end
                S_MD: begin
                    acc   <= acc + prod;
                    state <= S_OUT;
                end
                S_OUT: begin
                    u       <= u_n;
                    u_valid <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_sequencer.sv
// Randomised and directed bench for pid_sequencer against a cycle-count reference model.
module tb_pid_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] setpoint = '0;
    logic [15:0] feedback = '0;
    logic [15:0] kp = '0;
    logic [15:0] ki = '0;
    logic [15:0] kd = '0;
    logic        clr = 1'b0;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_p;
    logic [15:0] u;
    logic        u_valid;
    logic        busy;
    logic [7:0]  drop_cnt;

    logic [31:0] full_prod;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_i = 0, m_ep = 0, m_e = 0, m_d = 0;
    int m_u = 0, m_uv = 0, m_drop = 0, ph = -1;
    int gp = 0, gi = 0, gd = 0;

    int uv_count = 0;
    int last_u = 0;

    always #5 clk = ~clk;

    // external multiplier: low 16 bits, combinational
    assign full_prod = mul_a * mul_b;
    assign mul_p = full_prod[15:0];

    pid_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_valid(sample_valid),
        .setpoint(setpoint),
        .feedback(feedback),
        .kp(kp),
        .ki(ki),
        .kd(kd),
        .clr(clr),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_p(mul_p),
        .u(u),
        .u_valid(u_valid),
        .busy(busy),
        .drop_cnt(drop_cnt)
    );

    function automatic int sat16(int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int wrap16(int x);
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
    endfunction

    function automatic int s16(logic [15:0] x);
        return int'($signed(x));
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_i = 0; m_ep = 0; m_e = 0; m_d = 0;
            m_u = 0; m_uv = 0; m_drop = 0; ph = -1;
            return;
        end
        m_uv = 0;
        if (ph >= 0) begin
            if (sample_valid && m_drop < 255) m_drop++;
            ph++;
            if (ph == 2) gp = s16(kp);
            if (ph == 3) gi = s16(ki);
            if (ph == 4) gd = s16(kd);
            if (ph == 5) begin
                m_u = sat16(wrap16(gp * m_e) + wrap16(gi * m_i)
                            + wrap16(gd * m_d));
                m_uv = 1;
                ph = -1;
            end
        end else begin
            if (clr) begin
                m_i = 0;
                m_ep = 0;
            end
            if (sample_valid) begin
                m_e = sat16(s16(setpoint) - s16(feedback));
                m_i = sat16(m_i + m_e);
`ifdef PID_ANTIWINDUP_EN
                if (m_i > 8192) m_i = 8192;
                if (m_i < -8192) m_i = -8192;
`endif
                m_d = sat16(m_e - m_ep);
                m_ep = m_e;
                ph = 0;
            end
        end
    endtask

    // one clock: operand check before the edge, outputs checked after it
    task automatic cycle();
        int ea, eb;
        @(negedge clk);
        ea = 0;
        eb = 0;
        if (ph == 1) begin ea = s16(kp); eb = m_e; end
        if (ph == 2) begin ea = s16(ki); eb = m_i; end
        if (ph == 3) begin ea = s16(kd); eb = m_d; end
        chk("mul_a", s16(mul_a), ea);
        chk("mul_b", s16(mul_b), eb);
        @(posedge clk);
        model_edge();
        #1;
        chk("u", s16(u), m_u);
        chk("u_valid", int'(u_valid), m_uv);
        chk("busy", int'(busy), int'(ph >= 0));
        chk("drop_cnt", int'(drop_cnt), m_drop);
        if (u_valid) begin
            uv_count++;
            last_u = s16(u);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        clr = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic send(int sp, int fb, logic c);
        setpoint = 16'(sp);
        feedback = 16'(fb);
        sample_valid = 1'b1;
        clr = c;
        cycle();
        sample_valid = 1'b0;
        clr = 1'b0;
        repeat (5) cycle();
    endtask

    task automatic gains(int p, int i_g, int d_g);
        kp = 16'(p);
        ki = 16'(i_g);
        kd = 16'(d_g);
    endtask

    initial begin
        do_reset();
        chk("reset_u", s16(u), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_drop", int'(drop_cnt), 0);

        // proportional, with operand check in the MP cycle
        gains(2, 0, 0);
        setpoint = 16'd100;
        feedback = 16'd40;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
        cycle();
        chk("mp_mul_a", s16(mul_a), 2);
        chk("mp_mul_b", s16(mul_b), 60);
        repeat (4) cycle();
        chk("prop_u", last_u, 120);

        // integral
        do_reset();
        gains(0, 1, 0);
        send(10, 0, 1'b0);
        chk("int_u1", last_u, 10);
        send(10, 0, 1'b0);
        chk("int_u2", last_u, 20);
        send(10, 0, 1'b0);
        chk("int_u3", last_u, 30);
        send(10, 0, 1'b1);
        chk("int_clr", last_u, 10);

        // derivative
        do_reset();
        gains(0, 0, 3);
        send(10, 0, 1'b0);
        chk("der_u1", last_u, 30);
        send(10, 0, 1'b0);
        chk("der_u2", last_u, 0);
        send(-5, 0, 1'b0);
        chk("der_u3", last_u, -45);

        // saturation; a follow-up zero-error sample exposes i through ki
        do_reset();
        gains(1, 1, 1);
        send(32767, -32768, 1'b0);
        chk("sat_u", last_u, 32767);
        gains(0, 1, 0);
        send(0, 0, 1'b0);
`ifdef PID_ANTIWINDUP_EN
        chk("sat_i", last_u, 8192);
`else
        chk("sat_i", last_u, 32767);
`endif

        // busy drop
        do_reset();
        gains(1, 0, 0);
        uv_count = 0;
        setpoint = 16'd5;
        feedback = 16'd0;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
        cycle();
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
        repeat (6) cycle();
        chk("drop_one_uv", uv_count, 1);
        chk("drop_one_cnt", int'(drop_cnt), 1);
        sample_valid = 1'b1;
        repeat (360) cycle();
        sample_valid = 1'b0;
        repeat (6) cycle();
        chk("drop_sat", int'(drop_cnt), 255);

        // reset mid-sample
        do_reset();
        gains(0, 1, 0);
        setpoint = 16'd7;
        feedback = 16'd0;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        uv_count = 0;
        repeat (5) cycle();
        chk("mid_rst_uv", uv_count, 0);
        chk("mid_rst_u", s16(u), 0);
        chk("mid_rst_busy", int'(busy), 0);
        send(5, 0, 1'b0);
        chk("mid_rst_i", last_u, 5);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            sample_valid = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 7) == 0);
            setpoint = 16'($urandom);
            feedback = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                kp = 16'($urandom);
                ki = 16'($urandom);
                kd = 16'($urandom);
            end else begin
                kp = 16'($urandom_range(0, 6));
                ki = 16'($urandom_range(0, 6));
                kd = 16'($urandom_range(0, 6));
            end
            cycle();
        end
        rst_n = 1'b1;
        sample_valid = 1'b0;
        repeat (8) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
